// File: rtl/tlb.sv
// Joint TLB: TLBNUM 4 KB page-pair entries, two registered translation ports,
// a registered CP0 probe port and a combinational CP0 read port.
module tlb #(
   parameter int TLBNUM       = 16,
   parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    s0_req,
   input  logic [18:0]             s0_vpn2,
   input  logic                    s0_odd,
   input  logic [7:0]              s0_asid,
   output logic                    s0_rvalid,
   output logic                    s0_found,
   output logic [TLBNUM_WIDTH-1:0] s0_index,
   output logic [19:0]             s0_pfn,
   output logic [2:0]              s0_c,
   output logic                    s0_d,
   output logic                    s0_v,

   input  logic                    s1_req,
   input  logic [18:0]             s1_vpn2,
   input  logic                    s1_odd,
   input  logic [7:0]              s1_asid,
   output logic                    s1_rvalid,
   output logic                    s1_found,
   output logic [TLBNUM_WIDTH-1:0] s1_index,
   output logic [19:0]             s1_pfn,
   output logic [2:0]              s1_c,
   output logic                    s1_d,
   output logic                    s1_v,

   input  logic                    p_req,
   input  logic [18:0]             p_vpn2,
   input  logic [7:0]              p_asid,
   output logic                    p_done,
   output logic [TLBNUM_WIDTH:0]   p_result,

   input  logic                    we,
   input  logic [TLBNUM_WIDTH-1:0] w_index,
   input  logic [18:0]             w_vpn2,
   input  logic [7:0]              w_asid,
   input  logic                    w_g,
   input  logic [19:0]             w_pfn0,
   input  logic [2:0]              w_c0,
   input  logic                    w_d0,
   input  logic                    w_v0,
   input  logic [19:0]             w_pfn1,
   input  logic [2:0]              w_c1,
   input  logic                    w_d1,
   input  logic                    w_v1,

   input  logic [TLBNUM_WIDTH-1:0] r_index,
   output logic [18:0]             r_vpn2,
   output logic [7:0]              r_asid,
   output logic                    r_g,
   output logic [19:0]             r_pfn0,
   output logic [2:0]              r_c0,
   output logic                    r_d0,
   output logic                    r_v0,
   output logic [19:0]             r_pfn1,
   output logic [2:0]              r_c1,
   output logic                    r_d1,
   output logic                    r_v1
);

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
   } tag_t;

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic                    found;
      logic [TLBNUM_WIDTH-1:0] index;
   } hit_t;

   tag_t  tag   [TLBNUM];
   page_t page0 [TLBNUM];
   page_t page1 [TLBNUM];

   // Lowest matching index wins: scan downward so the last assignment is the lowest hit.
   function automatic hit_t find(input logic [18:0] vpn2, input logic [7:0] asid);
      hit_t res;
      res = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (tag[i].vpn2 == vpn2 && (tag[i].g || tag[i].asid == asid)) begin
            res.found = 1'b1;
            res.index = TLBNUM_WIDTH'(i);
         end
      end
      return res;
   endfunction

   // NOTE: the array is cleared in reset; software relies on all entries invalid after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TLBNUM; i++) begin
            tag[i]   <= '0;
            page0[i] <= '0;
            page1[i] <= '0;
         end
      end else if (we) begin
         tag[w_index]   <= '{vpn2: w_vpn2, asid: w_asid, g: w_g};
         page0[w_index] <= '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0};
         page1[w_index] <= '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1};
      end
   end

   hit_t  s0_hit, s1_hit, p_hit;
   page_t s0_sel, s1_sel;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      s0_sel = '0;
      s1_sel = '0;
      s0_hit = find(s0_vpn2, s0_asid);
      s1_hit = find(s1_vpn2, s1_asid);
      p_hit  = find(p_vpn2, p_asid);
      if (s0_hit.found) s0_sel = s0_odd ? page1[s0_hit.index] : page0[s0_hit.index];
      if (s1_hit.found) s1_sel = s1_odd ? page1[s1_hit.index] : page0[s1_hit.index];
   end

   hit_t  s0_hit_q, s1_hit_q;
   page_t s0_page_q, s1_page_q;

   // NOTE: state uses non-blocking assignments so a same-edge write is invisible to the lookups.
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_rvalid <= 1'b0;
         s1_rvalid <= 1'b0;
         p_done    <= 1'b0;
         s0_hit_q  <= '0;
         s1_hit_q  <= '0;
         s0_page_q <= '0;
         s1_page_q <= '0;
         p_result  <= {1'b1, {TLBNUM_WIDTH{1'b0}}};
      end else begin
         s0_rvalid <= s0_req;
         s1_rvalid <= s1_req;
         p_done    <= p_req;
         if (s0_req) begin
            s0_hit_q  <= s0_hit;
            s0_page_q <= s0_sel;
         end
         if (s1_req) begin
            s1_hit_q  <= s1_hit;
            s1_page_q <= s1_sel;
         end
         if (p_req) p_result <= p_hit.found ? {1'b0, p_hit.index} : {1'b1, {TLBNUM_WIDTH{1'b0}}};
      end
   end

   assign s0_found = s0_hit_q.found;
   assign s0_index = s0_hit_q.index;
   assign s0_pfn   = s0_page_q.pfn;
   assign s0_c     = s0_page_q.c;
   assign s0_d     = s0_page_q.d;
   assign s0_v     = s0_page_q.v;

   assign s1_found = s1_hit_q.found;
   assign s1_index = s1_hit_q.index;
   assign s1_pfn   = s1_page_q.pfn;
   assign s1_c     = s1_page_q.c;
   assign s1_d     = s1_page_q.d;
   assign s1_v     = s1_page_q.v;

   assign r_vpn2 = tag[r_index].vpn2;
   assign r_asid = tag[r_index].asid;
   assign r_g    = tag[r_index].g;
   assign r_pfn0 = page0[r_index].pfn;
   assign r_c0   = page0[r_index].c;
   assign r_d0   = page0[r_index].d;
   assign r_v0   = page0[r_index].v;
   assign r_pfn1 = page1[r_index].pfn;
   assign r_c1   = page1[r_index].c;
   assign r_d1   = page1[r_index].d;
   assign r_v1   = page1[r_index].v;

endmodule

// File: tb/tb_tlb.sv
// Directed bench for tlb: reset, lookup, global match, write/lookup ordering,
// multiple-match priority and back-to-back traffic with a mid-stream reset.
module tb_tlb;

   localparam int TLBNUM = 16;
   localparam int W      = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          s0_req, s1_req, p_req, we;
   logic [18:0]   s0_vpn2, s1_vpn2, p_vpn2, w_vpn2, r_vpn2;
   logic          s0_odd, s1_odd;
   logic [7:0]    s0_asid, s1_asid, p_asid, w_asid, r_asid;
   logic          s0_rvalid, s1_rvalid, s0_found, s1_found, p_done;
   logic [W-1:0]  s0_index, s1_index, w_index, r_index;
   logic [19:0]   s0_pfn, s1_pfn, w_pfn0, w_pfn1, r_pfn0, r_pfn1;
   logic [2:0]    s0_c, s1_c, w_c0, w_c1, r_c0, r_c1;
   logic          s0_d, s1_d, s0_v, s1_v;
   logic          w_g, w_d0, w_v0, w_d1, w_v1, r_g, r_d0, r_v0, r_d1, r_v1;
   logic [W:0]    p_result;

   int errors = 0;
   int checks = 0;

   tlb #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset),
      .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
      .s0_rvalid(s0_rvalid), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
      .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
      .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
      .s1_rvalid(s1_rvalid), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
      .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
      .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid), .p_done(p_done), .p_result(p_result),
      .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
      .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
      .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
      .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
      .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
      .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input logic [W-1:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                              input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                              input logic d0, input logic v0, input logic [19:0] pfn1,
                              input logic [2:0] c1, input logic d1, input logic v1);
      we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
      w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
      w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
      tick();
      we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (s0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_s0_rvalid: got %b want 0", s0_rvalid); end
      checks++; if (s1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_s1_rvalid: got %b want 0", s1_rvalid); end
      checks++; if (p_done !== 1'b0) begin errors++; $display("FAIL reset_p_done: got %b want 0", p_done); end
      checks++; if (p_result !== 5'h10) begin errors++; $display("FAIL reset_p_result: got %h want 10", p_result); end
      checks++; if ({s0_found, s0_index, s0_pfn} !== '0) begin errors++; $display("FAIL reset_s0_outputs: got %b/%h/%h want 0", s0_found, s0_index, s0_pfn); end
      reset = 1'b0;
      s0_req = 1'b1; s0_vpn2 = 19'h00001; s0_odd = 1'b0; s0_asid = 8'h00;
      p_req = 1'b1; p_vpn2 = 19'h00001; p_asid = 8'h00;
      r_index = 4'd0;
      tick();
      s0_req = 1'b0; p_req = 1'b0;
      checks++; if (s0_rvalid !== 1'b1) begin errors++; $display("FAIL empty_s0_rvalid: got %b want 1", s0_rvalid); end
      checks++; if (s0_found !== 1'b0 || s0_pfn !== 20'h0) begin errors++; $display("FAIL empty_s0_miss: got found=%b pfn=%h want 0/0", s0_found, s0_pfn); end
      checks++; if (p_done !== 1'b1 || p_result !== 5'h10) begin errors++; $display("FAIL empty_probe: got done=%b res=%h want 1/10", p_done, p_result); end
      checks++; if (r_vpn2 !== 19'h0 || r_v0 !== 1'b0) begin errors++; $display("FAIL reset_read: got vpn2=%h v0=%b want 0/0", r_vpn2, r_v0); end
      tick();
      checks++; if (s0_rvalid !== 1'b0 || p_done !== 1'b0) begin errors++; $display("FAIL pulse_end: got rvalid=%b done=%b want 0/0", s0_rvalid, p_done); end
      checks++; if (p_result !== 5'h10) begin errors++; $display("FAIL probe_hold: got %h want 10", p_result); end
   endtask

   task automatic test_lookup();
      write_entry(4'd5, 19'h12345, 8'h07, 1'b0, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'hBBBBB, 3'd0, 1'b0, 1'b0);
      s1_req = 1'b1; s1_vpn2 = 19'h12345; s1_odd = 1'b1; s1_asid = 8'h07;
      tick();
      checks++; if (s1_rvalid !== 1'b1 || s1_found !== 1'b1 || s1_index !== 4'd5) begin errors++; $display("FAIL asid_hit: got rvalid=%b found=%b idx=%0d want 1/1/5", s1_rvalid, s1_found, s1_index); end
      checks++; if (s1_pfn !== 20'hBBBBB || s1_v !== 1'b0 || s1_c !== 3'd0) begin errors++; $display("FAIL odd_page: got pfn=%h v=%b c=%0d want BBBBB/0/0", s1_pfn, s1_v, s1_c); end
      s1_asid = 8'h08;
      tick();
      s1_req = 1'b0;
      checks++; if (s1_found !== 1'b0 || s1_index !== 4'd0 || s1_pfn !== 20'h0) begin errors++; $display("FAIL asid_miss: got found=%b idx=%0d pfn=%h want 0/0/0", s1_found, s1_index, s1_pfn); end
      tick();
      checks++; if (s1_rvalid !== 1'b0 || s1_found !== 1'b0) begin errors++; $display("FAIL result_hold: got rvalid=%b found=%b want 0/0", s1_rvalid, s1_found); end
   endtask

   task automatic test_global();
      write_entry(4'd5, 19'h12345, 8'h07, 1'b1, 20'hAAAAA, 3'd3, 1'b1, 1'b1, 20'hBBBBB, 3'd0, 1'b0, 1'b0);
      s1_req = 1'b1; s1_vpn2 = 19'h12345; s1_odd = 1'b0; s1_asid = 8'hFF;
      tick();
      s1_req = 1'b0;
      checks++; if (s1_found !== 1'b1 || s1_index !== 4'd5) begin errors++; $display("FAIL global_hit: got found=%b idx=%0d want 1/5", s1_found, s1_index); end
      checks++; if (s1_pfn !== 20'hAAAAA || s1_c !== 3'd3 || s1_d !== 1'b1 || s1_v !== 1'b1) begin errors++; $display("FAIL even_page: got pfn=%h c=%0d d=%b v=%b want AAAAA/3/1/1", s1_pfn, s1_c, s1_d, s1_v); end
   endtask

   task automatic test_write_ordering();
      r_index = 4'd9;
      s0_req = 1'b1; s0_vpn2 = 19'h0ABCD; s0_odd = 1'b0; s0_asid = 8'h11;
      p_req = 1'b1; p_vpn2 = 19'h0ABCD; p_asid = 8'h11;
      #1;
      checks++; if (r_vpn2 !== 19'h0) begin errors++; $display("FAIL read_before_write: got %h want 0", r_vpn2); end
      write_entry(4'd9, 19'h0ABCD, 8'h11, 1'b0, 20'h12345, 3'd2, 1'b0, 1'b1, 20'h54321, 3'd5, 1'b1, 1'b1);
      checks++; if (s0_found !== 1'b0 || s0_rvalid !== 1'b1) begin errors++; $display("FAIL same_cycle_miss: got found=%b rvalid=%b want 0/1", s0_found, s0_rvalid); end
      checks++; if (p_result !== 5'h10) begin errors++; $display("FAIL same_cycle_probe: got %h want 10", p_result); end
      checks++; if (r_vpn2 !== 19'h0ABCD || r_asid !== 8'h11 || r_pfn0 !== 20'h12345 || r_pfn1 !== 20'h54321 || r_c1 !== 3'd5) begin
         errors++; $display("FAIL read_after_write: got vpn2=%h asid=%h pfn0=%h pfn1=%h c1=%0d", r_vpn2, r_asid, r_pfn0, r_pfn1, r_c1); end
      tick();
      s0_req = 1'b0; p_req = 1'b0;
      checks++; if (s0_found !== 1'b1 || s0_index !== 4'd9 || s0_pfn !== 20'h12345) begin errors++; $display("FAIL next_cycle_hit: got found=%b idx=%0d pfn=%h want 1/9/12345", s0_found, s0_index, s0_pfn); end
      checks++; if (p_result !== 5'h09) begin errors++; $display("FAIL next_cycle_probe: got %h want 09", p_result); end
   endtask

   task automatic test_multi_match();
      write_entry(4'd12, 19'h07777, 8'h22, 1'b0, 20'h0000C, 3'd0, 1'b0, 1'b1, 20'h000CC, 3'd0, 1'b0, 1'b1);
      write_entry(4'd3,  19'h07777, 8'h22, 1'b0, 20'h00003, 3'd0, 1'b0, 1'b1, 20'h00033, 3'd0, 1'b0, 1'b1);
      s0_req = 1'b1; s0_vpn2 = 19'h07777; s0_odd = 1'b0; s0_asid = 8'h22;
      p_req = 1'b1; p_vpn2 = 19'h07777; p_asid = 8'h22;
      tick();
      s0_req = 1'b0; p_req = 1'b0;
      checks++; if (s0_index !== 4'd3 || s0_pfn !== 20'h00003) begin errors++; $display("FAIL multi_lookup: got idx=%0d pfn=%h want 3/00003", s0_index, s0_pfn); end
      checks++; if (p_result !== 5'h03) begin errors++; $display("FAIL multi_probe: got %h want 03", p_result); end
   endtask

   // s0/probe use ASID 0x22 with even pages, s1 uses ASID 0x11 with odd pages; reset in cycle 4.
   task automatic test_back_to_back();
      logic [18:0] v0_tab [8] = '{19'h12345, 19'h0ABCD, 19'h07777, 19'h00001, 19'h12345, 19'h07777, 19'h12345, 19'h0ABCD};
      logic [18:0] v1_tab [8] = '{19'h0ABCD, 19'h12345, 19'h00001, 19'h0ABCD, 19'h07777, 19'h0ABCD, 19'h0ABCD, 19'h12345};
      logic        f0_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0]  i0_tab [8] = '{4'd5, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      logic [19:0] p0_tab [8] = '{20'hAAAAA, 20'h0, 20'h00003, 20'h0, 20'h0, 20'h0, 20'h0, 20'h0};
      logic        f1_tab [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0]  i1_tab [8] = '{4'd9, 4'd5, 4'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0};
      logic [19:0] p1_tab [8] = '{20'h54321, 20'hBBBBB, 20'h0, 20'h54321, 20'h0, 20'h0, 20'h0, 20'h0};
      logic [4:0]  pr_tab [8] = '{5'h05, 5'h10, 5'h03, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) begin
            if (c - 1 == 4) begin
               checks++; if (s0_rvalid !== 1'b0 || s1_rvalid !== 1'b0 || p_done !== 1'b0) begin
                  errors++; $display("FAIL b2b_reset_drop: got %b%b%b want 000", s0_rvalid, s1_rvalid, p_done); end
               checks++; if (p_result !== 5'h10 || s0_found !== 1'b0) begin errors++; $display("FAIL b2b_reset_clear: got res=%h found=%b want 10/0", p_result, s0_found); end
            end else begin
               checks++; if (s0_rvalid !== 1'b1 || s0_found !== f0_tab[c-1] || s0_index !== i0_tab[c-1] || s0_pfn !== p0_tab[c-1]) begin
                  errors++; $display("FAIL b2b_s0[%0d]: got v=%b f=%b i=%0d pfn=%h want 1/%b/%0d/%h", c - 1, s0_rvalid, s0_found, s0_index, s0_pfn, f0_tab[c-1], i0_tab[c-1], p0_tab[c-1]); end
               checks++; if (s1_rvalid !== 1'b1 || s1_found !== f1_tab[c-1] || s1_index !== i1_tab[c-1] || s1_pfn !== p1_tab[c-1]) begin
                  errors++; $display("FAIL b2b_s1[%0d]: got v=%b f=%b i=%0d pfn=%h want 1/%b/%0d/%h", c - 1, s1_rvalid, s1_found, s1_index, s1_pfn, f1_tab[c-1], i1_tab[c-1], p1_tab[c-1]); end
               checks++; if (p_done !== 1'b1 || p_result !== pr_tab[c-1]) begin
                  errors++; $display("FAIL b2b_probe[%0d]: got done=%b res=%h want 1/%h", c - 1, p_done, p_result, pr_tab[c-1]); end
            end
         end
         if (c < 8) begin
            reset = (c == 4);
            s0_req = 1'b1; s0_vpn2 = v0_tab[c]; s0_odd = 1'b0; s0_asid = 8'h22;
            s1_req = 1'b1; s1_vpn2 = v1_tab[c]; s1_odd = 1'b1; s1_asid = 8'h11;
            p_req  = 1'b1; p_vpn2  = v0_tab[c]; p_asid = 8'h22;
            tick();
         end
      end
      reset = 1'b0; s0_req = 1'b0; s1_req = 1'b0; p_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      s0_req = 1'b0; s0_vpn2 = '0; s0_odd = 1'b0; s0_asid = '0;
      s1_req = 1'b0; s1_vpn2 = '0; s1_odd = 1'b0; s1_asid = '0;
      p_req = 1'b0; p_vpn2 = '0; p_asid = '0;
      we = 1'b0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
      w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
      w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
      r_index = '0;
      test_reset();
      test_lookup();
      test_global();
      test_write_ordering();
      test_multi_match();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlb.md
Name: tlb

Overview:
- Joint TLB array: the responder side of the CP0 TLB write/read ports and of the TLBP probe.
- Holds TLBNUM entries of 4 KB page pairs and serves two translation ports, one for instruction fetch (s0) and one for data (s1), each with a registered 1-cycle result.
- Also serves a CP0 probe port that returns the {P, index} result consumed by CP0 on tlbp, plus a combinational read port for tlbr.

Parameters:
- TLBNUM, 16, number of entries; power of two, 2..64.
- TLBNUM_WIDTH, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- s0_req / s1_req  in  1  lookup request strobe, per port.
- s0_vpn2 / s1_vpn2  in  19  VA[31:13].
- s0_odd / s1_odd  in  1  VA[12].
- s0_asid / s1_asid  in  8  current ASID.
- s0_rvalid / s1_rvalid  out  1  result valid, one cycle after req.
- s0_found / s1_found  out  1  hit.
- s0_index / s1_index  out  TLBNUM_WIDTH  hit index.
- s0_pfn / s1_pfn  out  20  selected page PFN.
- s0_c / s1_c  out  3  selected page cache attribute.
- s0_d / s1_d  out  1  selected page dirty bit.
- s0_v / s1_v  out  1  selected page valid bit.
- p_req  in  1  probe strobe; uses p_vpn2 and p_asid (EntryHi).
- p_vpn2  in  19  probe VPN2.
- p_asid  in  8  probe ASID.
- p_done  out  1  probe result valid.
- p_result  out  TLBNUM_WIDTH+1  probe result; MSB is P (1 = miss), low bits are the index.
- we  in  1  write enable.
- w_index  in  TLBNUM_WIDTH  entry to write.
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  in  19, 8, 1, 20, 3, 1, 1, 20, 3, 1, 1  entry fields for the write.
- r_index  in  TLBNUM_WIDTH  entry to read.
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  same widths as the write fields  fields of entry r_index.

Behaviour:
- Storage: per entry vpn2, asid, g, pfn0/1, c0/1, d0/1, v0/1.
- Reset: all entries g = v0 = v1 = d0 = d1 = 0; other entry fields are cleared to 0.
- Reset: all outputs 0; s*_rvalid = p_done = 0; p_result = {1, 0}.
- Reset mid-operation: any pending result is dropped; no rvalid or p_done fires in the cycle after reset.
- Write: on posedge with we = 1, entry[w_index] is updated in full. w_g is stored as given (CP0 already ANDs the two EntryLo G bits).
- Read port: purely combinational from the current array state. A write at w_index == r_index becomes visible the cycle after the write edge.
- Match rule, entry i: (vpn2_i == req_vpn2) && (g_i || asid_i == req_asid). PageMask is fixed at 4 KB.
- Multiple matches (software error): the lowest index wins, deterministically, for lookups and probe.
- Lookup (s0 and s1 independent, identical): request fields are matched in the request cycle against array state before that edge's write.
  - Results are registered at the edge; rvalid = 1 in the following cycle only.
  - Result registers hold their values until the next req.
  - pfn/c/d/v come from page 1 if odd, else page 0.
  - On miss: found = 0, index = 0, pfn/c/d/v = 0.
- Write/lookup same cycle: the lookup sees pre-write contents. A lookup in the cycle after the write sees new contents.
- Probe: p_req at cycle N; p_done = 1 and p_result valid at cycle N+1.
  - Hit: p_result = {0, index}. Miss: p_result = {1, 0}.
  - p_result holds until the next p_req; p_done is a single-cycle pulse.
  - Same pre-write visibility rule as lookups.
- Back-to-back requests every cycle on all three ports are supported with no stall; each port is fully pipelined at 1 result per cycle.
- No other state; no replacement logic (the Random index comes from CP0 via w_index).

Test Plan:
- Reset, then s0_req with vpn2=0x00001, odd=0, asid=0 -> next cycle s0_rvalid=1, s0_found=0, s0_pfn=0; p_req -> p_result={1,0}.
- Write index 5: vpn2=0x12345, asid=0x07, g=0, pfn0=0xAAAAA, c0=3, d0=1, v0=1, pfn1=0xBBBBB, v1=0. Then s1_req vpn2=0x12345, odd=1, asid=0x07 -> found=1, index=5, pfn=0xBBBBB, v=0. Same request with asid=0x08 -> found=0.
- Same entry rewritten with g=1 -> lookup with asid=0xFF hits at index 5 with odd=0 and returns pfn=0xAAAAA, c=3, d=1.
- Write index 9 and s0_req for the same vpn2 in the same cycle -> miss. Repeat the request the next cycle -> hit, index 9. r_index=9 shows the new fields the cycle after the write.
- Identical vpn2/asid written at indices 3 and 12 -> lookup and probe both report index 3; p_result={0,3}.
- Requests on s0, s1 and p every cycle for 8 cycles with varied vpn2, with reset asserted on cycle 4 -> each result appears exactly 1 cycle later; no rvalid or p_done in cycle 5; after reset all lookups miss.
